// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache.
//   16 lines x 4 words (256 bytes). Loads that miss allocate the whole line
//   by reading the backing memory one word at a time. Stores always go to
//   memory and update the cache only on a hit.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   cpu_read         load request (held stable while stall=1)
//   cpu_write        store request (held stable while stall=1); wins over cpu_read
//   cpu_address      byte address, bits [1:0] ignored
//   cpu_write_data   store data
//   cpu_read_data    load data, zero unless a load completes this cycle
//   stall            combinational pipeline freeze request
//   mem_write        backing memory write strobe
//   mem_address      backing memory word-aligned byte address
//   mem_write_data   backing memory write data
//   mem_read_data    backing memory asynchronous read data
//   hit_count        load hit counter (wraps)
//   miss_count       load miss counter (wraps)
module dcache_dm #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_write_data,
    output logic [31:0] cpu_read_data,
    output logic        stall,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam logic [3:0] WaitLast = 4'(MEM_WAIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StWrite
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] valid_q, valid_d;
    logic [1:0]  word_q, word_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] hit_q, hit_d;
    logic [31:0] miss_q, miss_d;
    // Marks the cycle in which a refilled load completes, so it is not
    // counted a second time as a hit.
    logic        fill_done_q, fill_done_d;

    // Storage without reset: contents are meaningless until valid is set.
    logic [23:0] tag_mem [16];
    logic [31:0] data_mem [64];

    logic [23:0] addr_tag;
    logic [3:0]  addr_index;
    logic [1:0]  addr_offset;
    logic        lookup_hit;
    logic [31:0] lookup_word;

    logic        data_we;
    logic [5:0]  data_waddr;
    logic [31:0] data_wdata;
    logic        tag_we;

    logic        stall_int;
    logic        mem_write_int;
    logic [31:0] read_data_int;

    logic        unused_addr_bits;

    assign addr_tag         = cpu_address[31:8];
    assign addr_index       = cpu_address[7:4];
    assign addr_offset      = cpu_address[3:2];
    assign unused_addr_bits = ^cpu_address[1:0];

    assign lookup_hit  = valid_q[addr_index] && (tag_mem[addr_index] == addr_tag);
    assign lookup_word = data_mem[{addr_index, addr_offset}];

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        word_d        = word_q;
        wait_d        = wait_q;
        hit_d         = hit_q;
        miss_d        = miss_q;
        fill_done_d   = 1'b0;
        stall_int     = 1'b0;
        mem_write_int = 1'b0;
        mem_address   = {cpu_address[31:2], 2'b00};
        read_data_int = 32'h0000_0000;
        data_we       = 1'b0;
        data_waddr    = {addr_index, addr_offset};
        data_wdata    = cpu_write_data;
        tag_we        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_write) begin
                    // Store (also when cpu_read is high): one stall cycle.
                    stall_int = 1'b1;
                    state_d   = StWrite;
                end else if (cpu_read) begin
                    if (lookup_hit) begin
                        read_data_int = lookup_word;
                        if (!fill_done_q) begin
                            hit_d = hit_q + 32'd1;
                        end
                    end else begin
                        stall_int = 1'b1;
                        miss_d    = miss_q + 32'd1;
                        word_d    = 2'd0;
                        wait_d    = 4'd0;
                        state_d   = StFill;
                    end
                end
            end

            StFill: begin
                stall_int   = 1'b1;
                mem_address = {addr_tag, addr_index, word_q, 2'b00};
                if (wait_q == WaitLast) begin
                    data_we    = 1'b1;
                    data_waddr = {addr_index, word_q};
                    data_wdata = mem_read_data;
                    wait_d     = 4'd0;
                    word_d     = word_q + 2'd1;
                    if (word_q == 2'd3) begin
                        tag_we              = 1'b1;
                        valid_d[addr_index] = 1'b1;
                        fill_done_d         = 1'b1;
                        state_d             = StIdle;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end

            StWrite: begin
                mem_write_int = 1'b1;
                // No write-allocate: only a resident line is updated.
                data_we       = lookup_hit;
                state_d       = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Reset must silence the combinational outputs immediately, even while a
    // request is held that would otherwise miss and stall.
    assign stall          = stall_int & rst_n;
    assign mem_write      = mem_write_int & rst_n;
    assign cpu_read_data  = rst_n ? read_data_int : 32'h0000_0000;
    assign mem_write_data = cpu_write_data;
    assign hit_count      = hit_q;
    assign miss_count     = miss_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            word_q      <= '0;
            wait_q      <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            word_q      <= word_d;
            wait_q      <= wait_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            fill_done_q <= fill_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[data_waddr] <= data_wdata;
        end
        if (tag_we) begin
            tag_mem[addr_index] <= addr_tag;
        end
    end

endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: scoreboard bench for dcache_dm. The driver predicts each
// transaction's outcome from a line-level cache model and a shadow memory,
// and a negedge monitor retires transactions as the DUT completes them.
module tb_dcache_dm;

    localparam int unsigned MW = 2;
    localparam int MissStalls = 4 * MW + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_address;
    logic [31:0] cpu_write_data;
    logic [31:0] cpu_read_data;
    logic        stall;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    dcache_dm #(.MEM_WAIT(MW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_address    (cpu_address),
        .cpu_write_data (cpu_write_data),
        .cpu_read_data  (cpu_read_data),
        .stall          (stall),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_load;
        int          stalls;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] hits;
        logic [31:0] misses;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model: shadow memory plus per-line valid/tag.
    logic [31:0] ref_mem [4096];
    bit          m_valid [16];
    logic [23:0] m_tag [16];
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    // Backing memory (16 KB window)
    logic [31:0] bmem [4096];
    assign mem_read_data = bmem[mem_address[13:2]];

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] v;
        v = i;
        return {v[15:0] ^ 16'h5A5A, ~v[15:0]};
    endfunction

    initial begin
        logic [11:0] pa;
        logic [31:0] pd;
        for (int i = 0; i < 4096; i++) bmem[i] = init_word(i);
        bmem['h41] = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            if (mem_write) begin
                pa = mem_address[13:2];
                pd = mem_write_data;
                @(posedge clk);
                bmem[pa] <= pd;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hits   = 32'd0;
        m_misses = 32'd0;
    endtask

    // kind: 0 = load, 1 = store, 2 = load and store both asserted
    task automatic do_req(input int kind, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int          idx;
        int          n;
        logic [23:0] tg;
        idx = int'(a[7:4]);
        tg  = a[31:8];
        e.addr  = {a[31:2], 2'b00};
        e.wdata = d;
        if (kind == 0) begin
            e.is_load = 1'b1;
            if (m_valid[idx] && m_tag[idx] == tg) begin
                e.stalls = 0;
                m_hits   = m_hits + 32'd1;
            end else begin
                e.stalls     = MissStalls;
                m_misses     = m_misses + 32'd1;
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
            end
            e.data = ref_mem[a[13:2]];
        end else begin
            e.is_load = 1'b0;
            e.stalls  = 1;
            e.data    = 32'h0;
            ref_mem[a[13:2]] = d;
        end
        e.hits   = m_hits;
        e.misses = m_misses;
        exp_q.push_back(e);

        cpu_read       = (kind != 1);
        cpu_write      = (kind != 0);
        cpu_address    = a;
        cpu_write_data = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > MissStalls + 20) begin
                errors++;
                $display("FAIL timeout: stall still %b after %0d cycles at %h", stall, n, a);
                finish_sim();
            end
        end
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor / scoreboard
    int   stall_cnt = 0;
    bit   cnt_pend = 1'b0;
    exp_t mon_e;
    logic [31:0] pend_hits, pend_misses;

    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            stall_cnt = 0;
            cnt_pend  = 1'b0;
        end else begin
            if (cnt_pend) begin
                chk("hit_count", hit_count, pend_hits);
                chk("miss_count", miss_count, pend_misses);
                cnt_pend = 1'b0;
            end
            if (!cpu_read || stall) chk("rdata_zero", cpu_read_data, 32'h0);
            if (stall) chk("no_write_while_stalled", {31'h0, mem_write}, 32'h0);
            if (cpu_read || cpu_write) begin
                if (stall) begin
                    stall_cnt++;
                end else begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_completion: addr %h with empty queue", cpu_address);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("stall_cycles", stall_cnt, mon_e.stalls);
                        if (mon_e.is_load) begin
                            chk("load_data", cpu_read_data, mon_e.data);
                            chk("load_no_write", {31'h0, mem_write}, 32'h0);
                        end else begin
                            chk("store_mem_write", {31'h0, mem_write}, 32'h1);
                            chk("store_mem_address", mem_address, mon_e.addr);
                            chk("store_mem_data", mem_write_data, mon_e.wdata);
                        end
                        pend_hits   = mon_e.hits;
                        pend_misses = mon_e.misses;
                        cnt_pend    = 1'b1;
                    end
                    stall_cnt = 0;
                end
            end else begin
                chk("idle_no_write", {31'h0, mem_write}, 32'h0);
            end
        end
    end

    initial begin
        logic [23:0] tags [4];
        int          kind;
        logic [31:0] a;
        tags[0] = 24'h000001;
        tags[1] = 24'h000011;
        tags[2] = 24'h000020;
        tags[3] = 24'h00003F;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        ref_mem['h41] = 32'hDEADBEEF;
        model_reset();

        // Reset state, with a would-miss load held to show stall is forced low.
        rst_n          = 1'b0;
        cpu_read       = 1'b1;
        cpu_write      = 1'b0;
        cpu_address    = 32'h0000_0104;
        cpu_write_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", {31'h0, stall}, 32'h0);
        chk("reset_mem_write", {31'h0, mem_write}, 32'h0);
        chk("reset_rdata", cpu_read_data, 32'h0);
        chk("reset_hits", hit_count, 32'h0);
        chk("reset_misses", miss_count, 32'h0);
        cpu_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Cold miss, then hits on the same line.
        do_req(0, 32'h0000_0104, 32'h0);
        do_req(0, 32'h0000_0100, 32'h0);
        do_req(0, 32'h0000_0108, 32'h0);
        do_req(0, 32'h0000_010C, 32'h0);
        @(negedge clk);
        chk("after_hits_hit_count", hit_count, 32'd3);
        chk("after_hits_miss_count", miss_count, 32'd1);
        @(posedge clk);
        #1;

        // Conflict eviction on index 0.
        do_req(0, 32'h0000_1104, 32'h0);
        do_req(0, 32'h0000_0104, 32'h0);
        @(negedge clk);
        chk("evict_miss_count", miss_count, 32'd3);
        @(posedge clk);
        #1;

        // Store hit, store miss, combined read+write.
        do_req(1, 32'h0000_0108, 32'h0000_CAFE);
        do_req(0, 32'h0000_0108, 32'h0);
        do_req(1, 32'h0000_2000, 32'h1234_5678);
        do_req(0, 32'h0000_2000, 32'h0);
        do_req(2, 32'h0000_0010, 32'hA5A5_0F0F);
        do_req(0, 32'h0000_0011, 32'h0);

        // Randomized traffic over a few tags and indices to get hits and conflicts.
        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 19);
            kind = (kind < 12) ? 0 : ((kind < 17) ? 1 : 2);
            a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_req(kind, a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        // Reset in the middle of a refill, after word 1 has been captured.
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        cpu_read    = 1'b1;
        cpu_write   = 1'b0;
        cpu_address = 32'h0000_2A00;
        repeat (2 * MW + 1) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midfill_stall", {31'h0, stall}, 32'h0);
        chk("midfill_mem_write", {31'h0, mem_write}, 32'h0);
        chk("midfill_rdata", cpu_read_data, 32'h0);
        chk("midfill_hits", hit_count, 32'h0);
        chk("midfill_misses", miss_count, 32'h0);
        cpu_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        do_req(0, 32'h0000_2A00, 32'h0);
        do_req(0, 32'h0000_2A08, 32'h0);
        do_req(0, 32'h0000_0104, 32'h0);
        @(negedge clk);
        chk("post_reset_miss_count", miss_count, 32'd2);
        chk("post_reset_hit_count", hit_count, 32'd1);

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("final_hits", hit_count, m_hits);
        chk("final_misses", miss_count, m_misses);
        finish_sim();
    end

endmodule
